// File: rtl/spi_fifo_bridge_if.sv
// spi_fifo_bridge_if
//   Bundles the host-side FIFO port and the SPI-block handshake of
//   spi_fifo_bridge into one interface.
//   Parameter: AW - log2 of FIFO depth; level signals are AW+1 bits.
//   Modports:
//     slave  - view used by the bridge itself
//     master - view used by whatever drives the bridge (host + SPI block)
//   Host side : enable, host_wr, host_wdata, host_rd, host_rdata, tx_full,
//               tx_level, rx_empty, rx_level, busy, tx_ovf, rx_unf, flag_clr
//   SPI side  : spi_write, spi_data_out, spi_tx_ready, spi_rx_valid,
//               spi_read, spi_data_in
//   Optional  : timeout_err, present only when SPI_BRIDGE_TIMEOUT_EN is defined.
interface spi_fifo_bridge_if #(
  parameter int AW = 3
);
  logic          enable;
  logic          host_wr;
  logic [7:0]    host_wdata;
  logic          host_rd;
  logic [7:0]    host_rdata;
  logic          tx_full;
  logic [AW:0]   tx_level;
  logic          rx_empty;
  logic [AW:0]   rx_level;
  logic          busy;
  logic          tx_ovf;
  logic          rx_unf;
  logic          flag_clr;
  logic          spi_write;
  logic [7:0]    spi_data_out;
  logic          spi_tx_ready;
  logic          spi_rx_valid;
  logic          spi_read;
  logic [7:0]    spi_data_in;
`ifdef SPI_BRIDGE_TIMEOUT_EN
  logic          timeout_err;
`endif

  modport slave (
`ifdef SPI_BRIDGE_TIMEOUT_EN
    output timeout_err,
`endif
    input  enable, host_wr, host_wdata, host_rd, flag_clr,
    input  spi_tx_ready, spi_rx_valid, spi_data_in,
    output host_rdata, tx_full, tx_level, rx_empty, rx_level, busy,
    output tx_ovf, rx_unf, spi_write, spi_data_out, spi_read
  );

  modport master (
`ifdef SPI_BRIDGE_TIMEOUT_EN
    input  timeout_err,
`endif
    output enable, host_wr, host_wdata, host_rd, flag_clr,
    output spi_tx_ready, spi_rx_valid, spi_data_in,
    input  host_rdata, tx_full, tx_level, rx_empty, rx_level, busy,
    input  tx_ovf, rx_unf, spi_write, spi_data_out, spi_read
  );
endinterface

// File: rtl/spi_fifo_bridge.sv
// spi_fifo_bridge
//   Host-side buffering/sequencing stage in front of an SPI interface block.
//   Host bytes queue in a TX FIFO; a sequencer hands each one to the SPI
//   block (spi_write strobe), waits for the received byte (spi_rx_valid),
//   reads it back (spi_read strobe) and queues it in an RX FIFO for the host.
//   Exactly one byte returns per byte sent, in order.
//   Parameters: DEPTH (power of two, >=2), AW = log2(DEPTH), TIMEOUT.
//   Ports:
//     clk - system clock, rising edge
//     clr - asynchronous active-high reset
//     bus - spi_fifo_bridge_if.slave (host FIFO port + SPI handshake)
//   Optional feature macro: SPI_BRIDGE_TIMEOUT_EN
//     When defined, WAIT_RX gives up after TIMEOUT cycles, sets the sticky
//     timeout_err flag and returns to IDLE (the TX byte stays consumed).
module spi_fifo_bridge #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             clr,
  spi_fifo_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_RX, FETCH} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t          state_reg, state_next;

  logic [7:0]      tx_mem [DEPTH];
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [AW-1:0]   rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [AW:0]     tx_count_reg, rx_count_reg;
  logic [7:0]      data_out_reg;
  logic            tx_ovf_reg, rx_unf_reg;

  logic            tx_full, rx_empty;
  logic            tx_push, tx_pop, rx_push, rx_pop;
  logic            launch;

  assign tx_full  = (tx_count_reg == FULL_LVL);
  assign rx_empty = (rx_count_reg == '0);

  // Overflow/underflow attempts are dropped; the sticky flags record them.
  assign tx_push = bus.host_wr && !tx_full;
  assign tx_pop  = (state_reg == LOAD);
  // Launch reserved an RX slot, so the FETCH push never meets a full FIFO.
  assign rx_push = (state_reg == FETCH);
  assign rx_pop  = bus.host_rd && !rx_empty;

  assign launch = bus.enable && (tx_count_reg != '0) && bus.spi_tx_ready &&
                  (rx_count_reg < FULL_LVL);

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_reg;
  logic          timeout_err_reg;
  logic          timeout_hit;

  // wait_cnt_reg counts completed WAIT_RX cycles; expiry fires on the
  // TIMEOUT-th cycle without spi_rx_valid.
  assign timeout_hit = (wait_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == LOAD)
        wait_cnt_reg <= '0;
      else if (state_reg == WAIT_RX)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;

      if (bus.flag_clr)
        timeout_err_reg <= 1'b0;
      else if (state_reg == WAIT_RX && !bus.spi_rx_valid && timeout_hit)
        timeout_err_reg <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_reg;
`endif

  // Sequencer: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = LOAD;
      LOAD:    state_next = WAIT_RX;
      WAIT_RX: begin
        if (bus.spi_rx_valid)
          state_next = FETCH;
`ifdef SPI_BRIDGE_TIMEOUT_EN
        else if (timeout_hit)
          state_next = IDLE;
`endif
      end
      FETCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg     <= IDLE;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_count_reg  <= '0;
      data_out_reg  <= '0;
      tx_ovf_reg    <= 1'b0;
      rx_unf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;

      if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + 1'b1;
      else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - 1'b1;
      if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + 1'b1;
      else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - 1'b1;

      // Captured on entry to LOAD so it is valid for the whole LOAD cycle
      // and then simply holds until the next transfer.
      if (state_reg == IDLE && launch)
        data_out_reg <= tx_mem[tx_rd_ptr_reg];

      if (bus.flag_clr)
        tx_ovf_reg <= 1'b0;
      else if (bus.host_wr && tx_full)
        tx_ovf_reg <= 1'b1;

      if (bus.flag_clr)
        rx_unf_reg <= 1'b0;
      else if (bus.host_rd && rx_empty)
        rx_unf_reg <= 1'b1;
    end
  end

  // Storage carries no reset: emptiness is defined purely by the counters.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.host_wdata;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.spi_data_in;
  end

  assign bus.host_rdata   = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
  assign bus.tx_full      = tx_full;
  assign bus.tx_level     = tx_count_reg;
  assign bus.rx_empty     = rx_empty;
  assign bus.rx_level     = rx_count_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.tx_ovf       = tx_ovf_reg;
  assign bus.rx_unf       = rx_unf_reg;
  assign bus.spi_write    = (state_reg == LOAD);
  assign bus.spi_read     = (state_reg == FETCH);
  assign bus.spi_data_out = data_out_reg;

endmodule

// File: tb/tb_spi_fifo_bridge.sv
// tb_spi_fifo_bridge
//   Directed testbench for spi_fifo_bridge. A small SPI-block responder
//   answers every spi_write two cycles later with either a fixed byte or
//   (sent byte ^ 8'h5A), and holds the byte until spi_read has been seen.
//   Define SPI_BRIDGE_TIMEOUT_EN to also exercise the timeout path.
module tb_spi_fifo_bridge;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  spi_fifo_bridge_if #(.AW(AW)) bus();

  spi_fifo_bridge #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls
  logic       resp_en       = 1'b0;
  logic       resp_fixed_en = 1'b0;
  logic [7:0] resp_fixed    = 8'h00;
  logic [7:0] pend          = 8'h00;
  int         resp_cnt      = 0;
  logic       rd_prev       = 1'b0;

  logic [7:0] sent_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI block model, evaluated mid-cycle so its outputs are stable at posedge.
  always @(negedge clk) begin
    if (clr) begin
      bus.spi_rx_valid = 1'b0;
      bus.spi_data_in  = 8'h00;
      resp_cnt         = 0;
      rd_prev          = 1'b0;
    end else begin
      if (rd_prev) bus.spi_rx_valid = 1'b0;
      rd_prev = bus.spi_read;
      if (bus.spi_write && resp_en) begin
        pend     = resp_fixed_en ? resp_fixed : (bus.spi_data_out ^ 8'h5A);
        resp_cnt = 2;
      end else if (resp_cnt != 0) begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) begin
          bus.spi_rx_valid = 1'b1;
          bus.spi_data_in  = pend;
        end
      end
    end
  end

  // Record every byte offered to the SPI block.
  always @(negedge clk) begin
    if (!clr && bus.spi_write) sent_q.push_back(bus.spi_data_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.host_wr    = 1'b1;
    bus.host_wdata = d;
    tick();
    bus.host_wr    = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, bus.host_rdata, exp);
    bus.host_rd = 1'b1;
    tick();
    bus.host_rd = 1'b0;
  endtask

  task automatic wait_write(input string tag, input int limit);
    for (int k = 0; k < limit && !bus.spi_write; k++) tick();
    check(tag, bus.spi_write, 1'b1);
  endtask

  initial begin
    int base;
    int npushed;
    int ngot;
    int cyc;
    logic [7:0] d;
    logic [7:0] exp_q [$];

    bus.enable       = 1'b0;
    bus.host_wr      = 1'b0;
    bus.host_wdata   = 8'h00;
    bus.host_rd      = 1'b0;
    bus.flag_clr     = 1'b0;
    bus.spi_tx_ready = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_tx_level", bus.tx_level, 0);
    check("rst_tx_full", bus.tx_full, 0);
    check("rst_rx_empty", bus.rx_empty, 1);
    check("rst_rx_level", bus.rx_level, 0);
    check("rst_host_rdata", bus.host_rdata, 8'h00);
    check("rst_busy", bus.busy, 0);
    check("rst_spi_write", bus.spi_write, 0);
    check("rst_spi_read", bus.spi_read, 0);
    check("rst_spi_data_out", bus.spi_data_out, 8'h00);
    check("rst_flags", {bus.tx_ovf, bus.rx_unf}, 2'b00);
    clr = 1'b0;
    tick();

    // ---- reset in the middle of WAIT_RX with three bytes still queued ----
    resp_en          = 1'b0;
    bus.spi_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    bus.enable = 1'b1;
    wait_write("midrst_launch", 10);
    tick();
    tick();
    check("midrst_pre_tx_level", bus.tx_level, 3);
    check("midrst_pre_busy", bus.busy, 1);
    clr = 1'b1;
    #1;
    check("midrst_tx_level", bus.tx_level, 0);
    check("midrst_rx_empty", bus.rx_empty, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_spi_write", bus.spi_write, 0);
    check("midrst_spi_read", bus.spi_read, 0);
    tick();
    clr        = 1'b0;
    bus.enable = 1'b0;
    tick();

    // ---- single loopback: send 0xA5, receive 0x3C ----
    resp_en       = 1'b1;
    resp_fixed_en = 1'b1;
    resp_fixed    = 8'h3C;
    bus.enable    = 1'b1;
    push(8'hA5);
    wait_write("single_write", 10);
    check("single_data_out", bus.spi_data_out, 8'hA5);
    tick();
    check("single_write_1cyc", bus.spi_write, 0);
    check("single_data_hold", bus.spi_data_out, 8'hA5);
    for (int k = 0; k < 10 && !bus.spi_read; k++) tick();
    check("single_read", bus.spi_read, 1);
    check("single_rx_empty_in_fetch", bus.rx_empty, 1);
    tick();
    check("single_read_1cyc", bus.spi_read, 0);
    check("single_rx_level", bus.rx_level, 1);
    check("single_rx_empty", bus.rx_empty, 0);
    pop_check("single_rdata", 8'h3C);
    check("single_drained", bus.rx_empty, 1);
    resp_fixed_en = 1'b0;

    // ---- fill TX, overflow, then stream into RX ----
    bus.enable = 1'b0;
    base = sent_q.size();
    for (int i = 1; i <= 9; i++) push(8'(i));
    check("ovf_tx_full", bus.tx_full, 1);
    check("ovf_tx_level", bus.tx_level, 8);
    check("ovf_tx_ovf", bus.tx_ovf, 1);
    bus.enable = 1'b1;
    repeat (80) tick();
    check("ovf_sent_count", sent_q.size() - base, 8);
    for (int i = 0; i < 8 && base + i < sent_q.size(); i++)
      check($sformatf("ovf_order_%0d", i), sent_q[base+i], 8'(i + 1));
    check("ovf_rx_level", bus.rx_level, 8);
    check("ovf_tx_level_after", bus.tx_level, 0);

    // ---- RX backpressure: RX full, one TX byte waiting ----
    push(8'h77);
    base = sent_q.size();
    repeat (6) tick();
    check("bp_no_write", sent_q.size() - base, 0);
    check("bp_busy", bus.busy, 0);
    check("bp_tx_level", bus.tx_level, 1);
    pop_check("bp_pop0", 8'h01 ^ 8'h5A);
    for (int k = 0; k < 2 && !bus.spi_write; k++) tick();
    check("bp_launch", bus.spi_write, 1);
    check("bp_data_out", bus.spi_data_out, 8'h77);
    repeat (8) tick();
    for (int i = 2; i <= 8; i++) pop_check($sformatf("bp_drain_%0d", i), 8'(i) ^ 8'h5A);
    pop_check("bp_drain_77", 8'h77 ^ 8'h5A);
    check("bp_rx_empty", bus.rx_empty, 1);
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
    check("ovf_cleared", bus.tx_ovf, 0);

    // ---- wrap-around: 20 bytes with the host reading continuously ----
    npushed = 0;
    ngot    = 0;
    cyc     = 0;
    while (ngot < 20 && cyc < 400) begin
      bus.host_wr = 1'b0;
      bus.host_rd = 1'b0;
      if (npushed < 20 && !bus.tx_full) begin
        d = 8'(npushed * 37 + 5);
        bus.host_wr    = 1'b1;
        bus.host_wdata = d;
        exp_q.push_back(d ^ 8'h5A);
        npushed++;
      end
      if (!bus.rx_empty) begin
        check($sformatf("wrap_%0d", ngot), bus.host_rdata, exp_q.pop_front());
        bus.host_rd = 1'b1;
        ngot++;
      end
      tick();
      cyc++;
    end
    bus.host_wr = 1'b0;
    bus.host_rd = 1'b0;
    check("wrap_count", ngot, 20);
    check("wrap_no_unf", bus.rx_unf, 0);
    check("wrap_no_ovf", bus.tx_ovf, 0);

    // ---- underflow and flag clear priority ----
    tick();
    bus.host_rd = 1'b1;
    tick();
    bus.host_rd = 1'b0;
    check("unf_set", bus.rx_unf, 1);
    check("unf_rx_level", bus.rx_level, 0);
    bus.host_rd  = 1'b1;
    bus.flag_clr = 1'b1;
    tick();
    bus.host_rd  = 1'b0;
    bus.flag_clr = 1'b0;
    check("unf_clr_priority", bus.rx_unf, 0);
    check("unf_rx_level2", bus.rx_level, 0);

`ifdef SPI_BRIDGE_TIMEOUT_EN
    // ---- SPI block never answers ----
    resp_en    = 1'b0;
    bus.enable = 1'b1;
    push(8'hC3);
    wait_write("tmo_launch", 10);
    bus.enable = 1'b0;
    repeat (TIMEOUT + 2) tick();
    check("tmo_err", bus.timeout_err, 1);
    check("tmo_idle", bus.busy, 0);
    check("tmo_rx_level", bus.rx_level, 0);
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
    check("tmo_err_clr", bus.timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_fifo_bridge.md
Name: spi_fifo_bridge

Overview:
Host-side buffering and sequencing stage that sits directly upstream of the SPI interface block. Host bytes are queued in a TX FIFO. A sequencer hands them one at a time to the SPI block with a WRITE/data handshake, waits for the received byte, reads it back with a READ pulse and stores it in an RX FIFO for the host. One byte goes out and one byte comes back per transfer, in strict order.

Parameters:
DEPTH, 8, entries per FIFO; power of two, minimum 2
AW, 3, log2(DEPTH); level outputs are AW+1 bits wide
TIMEOUT, 255, cycles allowed in WAIT_RX; used only when SPI_BRIDGE_TIMEOUT_EN is defined

Ports:
CLK  in  1  single system clock; all logic on the rising edge
CLR  in  1  reset, asynchronous, active-high
ENABLE  in  1  allows the sequencer to launch new transfers
HOST_WR  in  1  push HOST_WDATA into the TX FIFO
HOST_WDATA  in  8  byte to transmit
HOST_RD  in  1  pop the RX FIFO head
HOST_RDATA  out  8  RX FIFO head, first-word-fall-through; 0 when RX is empty
TX_FULL  out  1  TX FIFO full
TX_LEVEL  out  AW+1  TX occupancy
RX_EMPTY  out  1  RX FIFO empty
RX_LEVEL  out  AW+1  RX occupancy
BUSY  out  1  sequencer not in IDLE
TX_OVF  out  1  sticky: HOST_WR while full
RX_UNF  out  1  sticky: HOST_RD while empty
FLAG_CLR  in  1  clears TX_OVF, RX_UNF (and TIMEOUT_ERR)
SPI_WRITE  out  1  one-cycle load strobe to the SPI block
SPI_DATA_OUT  out  8  byte for the SPI block; valid while SPI_WRITE=1
SPI_TX_READY  in  1  SPI block can accept a byte
SPI_RX_VALID  in  1  SPI block holds a received byte
SPI_READ  out  1  one-cycle read strobe to the SPI block
SPI_DATA_IN  in  8  SPI received byte; valid while SPI_READ=1

Behaviour:
- Reset (CLR=1, asynchronous):
  - both FIFOs emptied; TX_FULL=0, TX_LEVEL=0, RX_EMPTY=1, RX_LEVEL=0, HOST_RDATA=0.
  - SPI_WRITE=0, SPI_READ=0, SPI_DATA_OUT=0, BUSY=0; all sticky flags 0; state IDLE.
  - Reset mid-transfer abandons the byte and discards all FIFO contents.
- FIFOs: circular buffers with AW-bit pointers that wrap from DEPTH-1 to 0. Level = count, 0..DEPTH.
- HOST_WR while TX_FULL=1: write ignored, TX_OVF set. This holds even if the sequencer pops the TX FIFO in the same cycle.
- HOST_RD while RX_EMPTY=1: ignored, RX_UNF set.
- Simultaneous push and pop on one FIFO (both legal): level unchanged, both pointers advance.
- FLAG_CLR has priority over setting a flag in the same cycle.
- Launch condition: ENABLE=1, TX_LEVEL>0, SPI_TX_READY=1, and RX_LEVEL<DEPTH. The RX check guarantees the returned byte always has space.
- FSM:
  - IDLE: BUSY=0. If the launch condition is true, go to LOAD next cycle.
  - LOAD (1 cycle): SPI_WRITE=1, SPI_DATA_OUT=TX head. TX FIFO pops on the edge ending LOAD. Next state WAIT_RX.
  - WAIT_RX: strobes 0. When SPI_RX_VALID=1 is sampled, go to FETCH.
  - FETCH (1 cycle): SPI_READ=1. SPI_DATA_IN is pushed into the RX FIFO on the edge ending FETCH. Next state IDLE.
- Timing: minimum 4 cycles per byte (IDLE→LOAD→WAIT_RX→FETCH). RX_EMPTY falls the cycle after FETCH.
- ENABLE=0 blocks new launches only; an in-flight transfer always completes.
- SPI_DATA_OUT holds its last value outside LOAD.
- A host pop of the RX FIFO in the FETCH cycle is legal; the push still succeeds.

Optional Feature:
SPI_BRIDGE_TIMEOUT_EN
- Defined:
  - adds a cycle counter, cleared on entry to WAIT_RX.
  - adds output TIMEOUT_ERR (1 bit, sticky, reset 0, cleared by FLAG_CLR).
  - if SPI_RX_VALID has not been seen after TIMEOUT cycles in WAIT_RX: TIMEOUT_ERR set, FSM returns to IDLE, no SPI_READ, no RX push. The TX byte is already consumed.
- Undefined: no counter, no TIMEOUT_ERR port, and WAIT_RX waits indefinitely.

Test Plan:
- Reset check: assert CLR mid-WAIT_RX with TX_LEVEL=3 -> immediately TX_LEVEL=0, RX_EMPTY=1, BUSY=0, SPI_WRITE=0, SPI_READ=0.
- Single loopback: push 0xA5, SPI_TX_READY=1, model returns 0x3C two cycles after SPI_WRITE -> SPI_WRITE high one cycle with SPI_DATA_OUT=0xA5; then SPI_READ high one cycle; then RX_LEVEL=1, HOST_RDATA=0x3C.
- Full/overflow: ENABLE=0, push 9 bytes 0x01..0x09 with DEPTH=8 -> TX_FULL=1, TX_LEVEL=8, TX_OVF=1. Then ENABLE=1 -> SPI_DATA_OUT order 0x01..0x08 and 0x09 never sent.
- RX backpressure: RX FIFO holds 8 bytes, TX holds 1 -> no SPI_WRITE. After one HOST_RD, the transfer launches within 2 cycles.
- Wrap-around: stream 20 bytes through with the host reading continuously -> RX output order matches the model exactly, with no loss.
- Flags/underflow: HOST_RD while RX empty -> RX_UNF=1, RX_LEVEL stays 0. Then FLAG_CLR together with a second underflow -> RX_UNF=0. (With SPI_BRIDGE_TIMEOUT_EN defined, holding SPI_RX_VALID=0 for TIMEOUT+2 cycles gives TIMEOUT_ERR=1, FSM back in IDLE, RX_LEVEL unchanged.)
